prog_updown_counter: RTL and testbench

Parametrised up/down counter with synchronous load, programmable modulo limit, wrap or saturate mode, terminal-count pulse, compare match and a sticky overflow flag. It is the general-purpose successor to the fixed 8-bit loadable up-counter. It is used as the timing and event-count primitive in the I/O tile wrapper. Output gating replaces the old tri-state output with a zero-forced bus, so it is safe for on-chip routing.

---
 rtl/prog_updown_counter.sv | 122 ++++++++++++
 tb/tb_prog_updown_counter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_updown_counter.sv
// Parametrised up/down counter: sync load, modulo limit, wrap/saturate, tc pulse, compare, sticky ovf.
// Optional prescaler built only when PRESCALER_EN is defined.
module prog_updown_counter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               en,
  input  logic               dir,
  input  logic               sat,
  input  logic [WIDTH-1:0]   max_val,
  input  logic [WIDTH-1:0]   cmp_val,
  input  logic               oe,
  input  logic               ovf_clr,
  input  logic [PRESC_W-1:0] presc_div,
  output logic [WIDTH-1:0]   count_out,
  output logic               tc,
  output logic               cmp_match,
  output logic               ovf
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             tick;
  logic             step;
  logic             wrap;
  logic [WIDTH-1:0] inc, dec;

`ifdef PRESCALER_EN
  logic [PRESC_W-1:0] presc_q, presc_d;

  // >= so that lowering presc_div below the current phase steps on the next enabled cycle
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (load) begin
      presc_d = '0;
    end else if (en) begin
      if (presc_q >= presc_div) begin
        tick    = 1'b1;
        presc_d = '0;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= presc_d;
  end
`else
  logic unused_presc;
  assign unused_presc = ^presc_div;
  assign tick         = 1'b1;
`endif

  assign step = ~load & en & tick;
  assign inc  = count_q + 1'b1;
  assign dec  = count_q - 1'b1;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    wrap    = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (step) begin
      if (dir) begin
        if (count_q >= max_val) begin
          if (sat) begin
            count_d = max_val;
          end else begin
            count_d = '0;
            tc_d    = 1'b1;
            wrap    = 1'b1;
          end
        end else begin
          count_d = inc;
          tc_d    = sat & (inc == max_val);
        end
      end else begin
        if (count_q == '0) begin
          if (!sat) begin
            count_d = max_val;
            tc_d    = 1'b1;
            wrap    = 1'b1;
          end
        end else if (count_q > max_val) begin
          count_d = max_val;
        end else begin
          count_d = dec;
          tc_d    = sat & (dec == '0);
        end
      end
    end
    // a wrap in the same cycle as ovf_clr wins
    ovf_d = wrap | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_out = oe ? count_q : '0;
  assign tc        = tc_q;
  assign ovf       = ovf_q;
  assign cmp_match = (count_q == cmp_val);

endmodule

// File: tb/tb_prog_updown_counter.sv
// Self-checking bench for prog_updown_counter: behavioural model compared every cycle plus directed literals.
module tb_prog_updown_counter;
  localparam int W  = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load, en, dir, sat, oe, ovf_clr;
  logic [W-1:0]  load_val, max_val, cmp_val;
  logic [PW-1:0] presc_div;
  logic [W-1:0]  count_out;
  logic          tc, cmp_match, ovf;

  prog_updown_counter #(.WIDTH(W), .PRESC_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .en(en),
    .dir(dir), .sat(sat), .max_val(max_val), .cmp_val(cmp_val), .oe(oe),
    .ovf_clr(ovf_clr), .presc_div(presc_div), .count_out(count_out),
    .tc(tc), .cmp_match(cmp_match), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model state as plain integers
  int m_count, m_tc, m_ovf, m_presc;

  always @(posedge clk or negedge rst_n) begin
    int c, mx, nx, t, w, stp;
    if (!rst_n) begin
      m_count = 0; m_tc = 0; m_ovf = 0; m_presc = 0;
    end else begin
      c = m_count; mx = int'(max_val); nx = c; t = 0; w = 0; stp = 0;
`ifdef PRESCALER_EN
      if (load) m_presc = 0;
      else if (en) begin
        if (m_presc >= int'(presc_div)) begin stp = 1; m_presc = 0; end
        else m_presc = m_presc + 1;
      end
`else
      stp = en && !load;
`endif
      if (load) nx = int'(load_val);
      else if (stp) begin
        if (dir && !sat) begin
          if (c >= mx) begin nx = 0; t = 1; w = 1; end else nx = c + 1;
        end else if (dir && sat) begin
          if (c >= mx) nx = mx; else begin nx = c + 1; t = (nx == mx); end
        end else if (!sat) begin
          if (c == 0) begin nx = mx; t = 1; w = 1; end
          else if (c > mx) nx = mx;
          else nx = c - 1;
        end else begin
          if (c == 0) nx = 0;
          else if (c > mx) nx = mx;
          else begin nx = c - 1; t = (nx == 0); end
        end
      end
      m_count = nx;
      m_tc    = t;
      if (w) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
    end
  end

  // directed literal expectations queued by the stimulus, checked in the compare process
  string lit_nm [512];
  int    lit_a  [512];
  int    lit_e  [512];
  int    lit_wr = 0;
  int    lit_rd = 0;

  task automatic lit(input string nm, input int act, input int exp);
    lit_nm[lit_wr] = nm;
    lit_a[lit_wr]  = act;
    lit_e[lit_wr]  = exp;
    lit_wr++;
  endtask

  always @(negedge clk) begin
    int e_out;
    e_out = oe ? m_count : 0;
    n_vec++;
    if (int'(count_out) != e_out || int'(tc) != m_tc || int'(ovf) != m_ovf ||
        int'(cmp_match) != int'(m_count == int'(cmp_val))) begin
      n_err++;
      $display("FAIL model t=%0t count_out=%0d/%0d tc=%0d/%0d ovf=%0d/%0d cmp=%0d/%0d (actual/required)",
               $time, count_out, e_out, tc, m_tc, ovf, m_ovf, cmp_match,
               int'(m_count == int'(cmp_val)));
    end
    while (lit_rd < lit_wr) begin
      n_vec++;
      if (lit_a[lit_rd] != lit_e[lit_rd]) begin
        n_err++;
        $display("FAIL %s actual=%0d required=%0d", lit_nm[lit_rd], lit_a[lit_rd], lit_e[lit_rd]);
      end
      lit_rd++;
    end
  end

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int exp_up[12];
  int exp_dn[5];

  initial begin
    exp_up = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    exp_dn = '{2, 1, 0, 0, 0};
    rst_n = 1'b0; load = 1'b0; en = 1'b0; dir = 1'b1; sat = 1'b0; oe = 1'b1;
    ovf_clr = 1'b0; load_val = '0; max_val = 8'd255; cmp_val = '0; presc_div = '0;
    #12;
    lit("rst_count_out", int'(count_out), 0);
    lit("rst_cmp_match", int'(cmp_match), 1);
    next_cyc();
    rst_n = 1'b1;
    lit("rst_tc", int'(tc), 0);
    lit("rst_ovf", int'(ovf), 0);

    // load and async reset
    load = 1'b1; load_val = 8'hF0;
    next_cyc();
    load = 1'b0;
    lit("load_f0", int'(count_out), 8'hF0);
    lit("load_no_tc", int'(tc), 0);
    en = 1'b1;
    next_cyc();
    next_cyc();
    lit("count_f2", int'(count_out), 8'hF2);
    #2 rst_n = 1'b0;
    #1 lit("async_rst", int'(count_out), 0);
    next_cyc();
    rst_n = 1'b1; en = 1'b0;

    // wrap up to max_val=9
    load = 1'b1; load_val = 8'd0; max_val = 8'd9; sat = 1'b0; dir = 1'b1; ovf_clr = 1'b1;
    next_cyc();
    load = 1'b0; ovf_clr = 1'b0;
    lit("wrap_ovf_init", int'(ovf), 0);
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      next_cyc();
      lit("wrap_up_cnt", int'(count_out), exp_up[i]);
      lit("wrap_up_tc", int'(tc), int'(exp_up[i] == 0));
      lit("wrap_up_ovf", int'(ovf), int'(i >= 9));
    end
    en = 1'b0; ovf_clr = 1'b1;
    next_cyc();
    ovf_clr = 1'b0;
    lit("ovf_cleared", int'(ovf), 0);

    // saturating down from 3
    load = 1'b1; load_val = 8'd3; sat = 1'b1; dir = 1'b0;
    next_cyc();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next_cyc();
      lit("sat_dn_cnt", int'(count_out), exp_dn[i]);
      lit("sat_dn_tc", int'(tc), int'(i == 2));
      lit("sat_dn_ovf", int'(ovf), 0);
    end

    // out-of-range start above max_val
    en = 1'b0; load = 1'b1; load_val = 8'd200; max_val = 8'd50; sat = 1'b0; dir = 1'b1;
    next_cyc();
    load = 1'b0;
    lit("load_200", int'(count_out), 200);
    en = 1'b1;
    next_cyc();
    lit("oor_up_cnt", int'(count_out), 0);
    lit("oor_up_tc", int'(tc), 1);
    lit("oor_up_ovf", int'(ovf), 1);
    en = 1'b0; load = 1'b1;
    next_cyc();
    load = 1'b0; dir = 1'b0; en = 1'b1;
    next_cyc();
    lit("oor_dn_cnt", int'(count_out), 50);
    lit("oor_dn_tc", int'(tc), 0);

    // oe gating, compare match, wrap beats ovf_clr
    en = 1'b0; load = 1'b1; load_val = 8'd0; max_val = 8'd9; dir = 1'b1; sat = 1'b0;
    cmp_val = 8'd5; oe = 1'b0; ovf_clr = 1'b1;
    next_cyc();
    load = 1'b0; ovf_clr = 1'b0; en = 1'b1;
    lit("cmp_ovf_init", int'(ovf), 0);
    for (int i = 1; i <= 10; i++) begin
      ovf_clr = (i == 10);
      next_cyc();
      lit("oe0_out", int'(count_out), 0);
      lit("cmp_match", int'(cmp_match), int'(i == 5));
    end
    ovf_clr = 1'b0;
    lit("set_beats_clr", int'(ovf), 1);
    lit("set_clr_tc", int'(tc), 1);

    // max_val = 0
    oe = 1'b1; en = 1'b0; load = 1'b1; load_val = 8'd0; max_val = 8'd0; cmp_val = 8'd0;
    next_cyc();
    load = 1'b0; en = 1'b1;
    next_cyc();
    lit("max0_wrap_cnt", int'(count_out), 0);
    lit("max0_wrap_tc", int'(tc), 1);
    next_cyc();
    lit("max0_wrap_tc2", int'(tc), 1);
    sat = 1'b1;
    next_cyc();
    lit("max0_sat_cnt", int'(count_out), 0);
    lit("max0_sat_tc", int'(tc), 0);
    sat = 1'b0; dir = 1'b0;
    next_cyc();
    lit("max0_dn_tc", int'(tc), 1);

`ifdef PRESCALER_EN
    en = 1'b0; load = 1'b1; load_val = 8'd0; max_val = 8'd255; sat = 1'b0; dir = 1'b1;
    presc_div = 4'd2;
    next_cyc();
    load = 1'b0; en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      next_cyc();
      lit("presc_cnt", int'(count_out), i / 3);
    end
    next_cyc();
    next_cyc();
    lit("presc_pre_hold", int'(count_out), 2);
    en = 1'b0;
    for (int i = 0; i < 3; i++) next_cyc();
    lit("presc_held", int'(count_out), 2);
    en = 1'b1;
    next_cyc();
    lit("presc_phase_kept", int'(count_out), 3);
`endif

    en = 1'b0;
    next_cyc();
    next_cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
